// File: rtl/switch_host_master_if.sv
// Command, response and register-bus signals of the on-chip host master.
// The master modport is the DUT view; slave is the view of whoever drives commands and answers the bus.
interface switch_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [15:0] rsp_polls;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic        chipselect;
  logic [31:0] readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_polls,
           writedata, write, read, address, chipselect
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_polls,
           writedata, write, read, address, chipselect
  );
endinterface

// File: rtl/switch_host_master.sv
// On-chip initiator for the switch register bus: single writes, reads and bounded poll-until-match.
// Optional strobe counters are enabled with the macro SWITCH_HOST_MASTER_STATS_EN.
module switch_host_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned MAX_POLLS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  switch_host_master_if.master bus,
  output logic [15:0]          stat_writes,
  output logic [15:0]          stat_reads
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 2;
  localparam int unsigned GW = 8;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_WR = 3'd1;
  localparam logic [2:0] ISSUE_RD = 3'd2;
  localparam logic [2:0] WAIT_RD  = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d, mask_q, mask_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0] polls_q, polls_d;
  logic [DW-1:0] writedata_q, writedata_d;
  logic [AW-1:0] address_q, address_d;
  logic          write_q, write_d, read_q, read_d, cs_q, cs_d;
  logic          issue_rd;
  logic          hit_c;

  assign hit_c = ((bus.readdata & mask_q) == (data_q & mask_q));

  // Next-state and next-output logic; every output register loads its value for the coming cycle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    mask_d        = mask_q;
    lat_d         = lat_q;
    gap_d         = gap_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    polls_d       = polls_q;
    writedata_d   = writedata_q;
    address_d     = address_q;
    write_d       = 1'b0;
    read_d        = 1'b0;
    cs_d          = 1'b0;
    issue_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d          = bus.cmd_op;
          data_d        = bus.cmd_data;
          mask_d        = bus.cmd_mask;
          address_d     = bus.cmd_addr;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          if (bus.cmd_op == OP_WRITE) begin
            state_d     = ISSUE_WR;
            write_d     = 1'b1;
            cs_d        = 1'b1;
            writedata_d = bus.cmd_data;
            polls_d     = '0;
          end else begin
            issue_rd = 1'b1;
            polls_d  = CW'(1);
          end
        end
      end
      ISSUE_WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      ISSUE_RD: begin
        state_d = WAIT_RD;
        lat_d   = LW'(READ_LATENCY - 1);
      end
      WAIT_RD: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          rsp_data_d = bus.readdata;
          if (op_q != OP_POLL || hit_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else if (polls_q >= CW'(MAX_POLLS)) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end else if (POLL_GAP == 0) begin
            issue_rd = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = GW'(POLL_GAP - 1);
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        else             issue_rd = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every read strobe counts as a poll; the first one was already counted on acceptance.
    if (issue_rd) begin
      state_d = ISSUE_RD;
      read_d  = 1'b1;
      cs_d    = 1'b1;
      if (state_q != IDLE && polls_q != '1) polls_d = polls_q + CW'(1);
    end
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      lat_q         <= '0;
      gap_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      polls_q       <= '0;
      writedata_q   <= '0;
      address_q     <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      cs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      lat_q         <= lat_d;
      gap_q         <= gap_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      polls_q       <= polls_d;
      writedata_q   <= writedata_d;
      address_q     <= address_d;
      write_q       <= write_d;
      read_q        <= read_d;
      cs_q          <= cs_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_polls   = polls_q;
  assign bus.writedata   = writedata_q;
  assign bus.address     = address_q;
  assign bus.write       = write_q;
  assign bus.read        = read_q;
  assign bus.chipselect  = cs_q;

`ifdef SWITCH_HOST_MASTER_STATS_EN
  // Free-running strobe counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_writes <= '0;
      stat_reads  <= '0;
    end else begin
      if (write_q) stat_writes <= stat_writes + 16'd1;
      if (read_q)  stat_reads  <= stat_reads + 16'd1;
    end
  end
`else
  assign stat_writes = '0;
  assign stat_reads  = '0;
`endif
endmodule
